// File: rtl/fft_frame_seq_if.sv
// Bin-level handshake, tag and status bundle between the FFT source, fft_mag_sq and spectral flux.
// master drives bins and frame_ready; slave is the frame sequencer.
interface fft_frame_seq_if #(
    parameter int N = 256
);
    localparam int IW = $clog2(N);

    logic          fft_valid;
    logic          fft_sop;
    logic          fft_eop;
    logic          fft_ready;
    logic          frame_ready;
    logic          dp_valid;
    logic          tag_valid;
    logic [IW-1:0] bin_idx;
    logic          bin_first;
    logic          bin_last;
    logic          frame_done;
    logic [15:0]   frame_count;
    logic          err_len;
    logic          err_nosop;

    modport master (
        output fft_valid, fft_sop, fft_eop, frame_ready,
        input  fft_ready, dp_valid, tag_valid, bin_idx, bin_first, bin_last,
               frame_done, frame_count, err_len, err_nosop
    );

    modport slave (
        input  fft_valid, fft_sop, fft_eop, frame_ready,
        output fft_ready, dp_valid, tag_valid, bin_idx, bin_first, bin_last,
               frame_done, frame_count, err_len, err_nosop
    );
endinterface

// File: rtl/fft_frame_seq.sv
// Frames FFT bins for fft_mag_sq: gates bins beyond KEEP, tags survivors, counts frames, flags errors.
// Latency: dp_valid combinational; tags LAT cycles after dp_valid; frame_done once the tag pipe drains.
// Backpressure: frame-level only -- fft_ready follows frame_ready in IDLE, 1 in RUN, 0 while draining.
module fft_frame_seq #(
    parameter int N    = 256,
    parameter int KEEP = N / 2,
    parameter int LAT  = 3
) (
    input  logic                clk,
    input  logic                reset,
    fft_frame_seq_if.slave      bus
);
    localparam int IW       = $clog2(N);
    localparam int KEEP_EFF = (KEEP < N) ? KEEP : N;

    localparam logic [IW:0]   KEEP_W    = (IW + 1)'(KEEP_EFF);
    localparam logic [IW-1:0] LAST_KEEP = IW'(KEEP_EFF - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic          vld;
        logic [IW-1:0] idx;
        logic          first;
        logic          last;
    } tag_t;

    state_t        state_q, state_d;
    logic [IW-1:0] bin_cnt_q, bin_cnt_d;
    tag_t          pipe_q [LAT];
    tag_t          tag_in;
    logic          err_len_q, err_len_d;
    logic          err_nosop_q, err_nosop_d;
    logic [15:0]   frame_count_q;

    logic          ready;
    logic          accepted;
    logic          dp;
    logic          done_now;
    logic          pipe_empty;
    logic [IW-1:0] eff_idx;
    logic          is_last_idx;
    logic          ends_frame;

    always_comb begin
        pipe_empty = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            if (pipe_q[i].vld) begin
                pipe_empty = 1'b0;
            end
        end
    end

    // A sop always restarts numbering at 0, whether it opens a frame or aborts one.
    always_comb begin
        eff_idx     = bus.fft_sop ? '0 : bin_cnt_q;
        is_last_idx = (eff_idx == LAST_IDX);
        ends_frame  = bus.fft_eop || is_last_idx;
    end

    always_comb begin
        state_d     = state_q;
        bin_cnt_d   = bin_cnt_q;
        ready       = 1'b0;
        accepted    = 1'b0;
        done_now    = 1'b0;
        err_len_d   = 1'b0;
        err_nosop_d = 1'b0;

        case (state_q)
            IDLE: begin
                ready = bus.frame_ready;
                if (bus.fft_valid) begin
                    if (bus.fft_sop && bus.frame_ready) begin
                        accepted = 1'b1;
                    end else begin
                        err_nosop_d = 1'b1;
                    end
                end
            end
            RUN: begin
                ready    = 1'b1;
                accepted = bus.fft_valid;
            end
            DRAIN: begin
                if (pipe_empty) begin
                    done_now = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accepted) begin
            err_len_d = ((state_q == RUN) && bus.fft_sop) || (bus.fft_eop != is_last_idx);
            if (ends_frame) begin
                state_d   = DRAIN;
                bin_cnt_d = '0;
            end else begin
                state_d   = RUN;
                bin_cnt_d = eff_idx + 1'b1;
            end
        end
    end

    always_comb begin
        dp     = accepted && ({1'b0, eff_idx} < KEEP_W);
        tag_in = '0;
        if (dp) begin
            tag_in.vld   = 1'b1;
            tag_in.idx   = eff_idx;
            tag_in.first = (eff_idx == '0);
            tag_in.last  = (eff_idx == LAST_KEEP) || bus.fft_eop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            bin_cnt_q     <= '0;
            err_len_q     <= 1'b0;
            err_nosop_q   <= 1'b0;
            frame_count_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            bin_cnt_q   <= bin_cnt_d;
            err_len_q   <= err_len_d;
            err_nosop_q <= err_nosop_d;
            if (done_now) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            pipe_q[0] <= tag_in;
            for (int i = 1; i < LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Combinational outputs are masked so nothing leaks out while reset is held.
    assign bus.fft_ready   = ready && !reset;
    assign bus.dp_valid    = dp && !reset;
    assign bus.frame_done  = done_now && !reset;
    assign bus.tag_valid   = pipe_q[LAT-1].vld;
    assign bus.bin_idx     = pipe_q[LAT-1].idx;
    assign bus.bin_first   = pipe_q[LAT-1].first;
    assign bus.bin_last    = pipe_q[LAT-1].last;
    assign bus.frame_count = frame_count_q;
    assign bus.err_len     = err_len_q;
    assign bus.err_nosop   = err_nosop_q;
endmodule

// File: tb/tb_fft_frame_seq.sv
// Randomised and directed bench for fft_frame_seq against a frame-level reference model.
module tb_fft_frame_seq;
    localparam int N    = 8;
    localparam int KEEP = 4;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    always #5 clk = ~clk;

    fft_frame_seq_if #(.N(N)) bus ();
    fft_frame_seq_if #(.N(N)) bus2 ();

    fft_frame_seq #(.N(N), .KEEP(KEEP), .LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fft_frame_seq #(.N(N), .KEEP(1), .LAT(1)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    typedef struct {
        int idx;
        bit first;
        bit last;
    } exp_t;

    typedef struct {
        int cyc;
        int idx;
        bit first;
        bit last;
    } log_t;

    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   len_cnt = 0;
    int   nosop_cnt = 0;
    int   dp_log[$];
    log_t tag_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model and monitor, evaluated mid-cycle.
    initial begin
        int   cyc;
        bit   rst_seen;
        bit   in_frame, drain;
        int   exp_idx, done_at, last_due, count, idx;
        bit   pend_len, pend_nosop;
        bit   acc, exp_ready, exp_dp, exp_done, len_nx, nosop_nx;
        exp_t exp_tag[int];
        cyc = 0; rst_seen = 0; in_frame = 0; drain = 0; exp_idx = 0;
        done_at = 0; last_due = -100; count = 0; pend_len = 0; pend_nosop = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                check("ready_in_reset", bus.fft_ready, 0);
                check("dp_in_reset", bus.dp_valid, 0);
                check("done_in_reset", bus.frame_done, 0);
                rst_seen = 1; in_frame = 0; drain = 0; exp_idx = 0; count = 0;
                pend_len = 0; pend_nosop = 0; last_due = -100;
                exp_tag.delete();
            end else if (rst_seen) begin
                exp_ready = drain ? 1'b0 : (in_frame ? 1'b1 : bus.frame_ready);
                acc       = bus.fft_valid && exp_ready && (in_frame || bus.fft_sop);
                nosop_nx  = !in_frame && !drain && bus.fft_valid && !acc;
                exp_dp    = 0;
                len_nx    = 0;
                idx       = 0;
                if (acc) begin
                    idx    = bus.fft_sop ? 0 : exp_idx;
                    len_nx = (in_frame && bus.fft_sop) || (bus.fft_eop != (idx == N - 1));
                    if (idx < KEEP) begin
                        exp_dp = 1;
                        exp_tag[cyc + LAT] = '{idx, idx == 0, (idx == KEEP - 1) || bus.fft_eop};
                        last_due = cyc + LAT;
                    end
                end
                exp_done = drain && (cyc >= done_at);

                check("fft_ready", bus.fft_ready, exp_ready);
                check("dp_valid", bus.dp_valid, exp_dp);
                check("frame_done", bus.frame_done, exp_done);
                check("frame_count", bus.frame_count, count);
                check("err_len", bus.err_len, pend_len);
                check("err_nosop", bus.err_nosop, pend_nosop);
                if (exp_tag.exists(cyc)) begin
                    check("tag_valid", bus.tag_valid, 1);
                    check("bin_idx", bus.bin_idx, exp_tag[cyc].idx);
                    check("bin_first", bus.bin_first, exp_tag[cyc].first);
                    check("bin_last", bus.bin_last, exp_tag[cyc].last);
                    exp_tag.delete(cyc);
                end else begin
                    check("tag_idle", bus.tag_valid, 0);
                end

                pend_len   = len_nx;
                pend_nosop = nosop_nx;
                if (exp_done) begin
                    drain = 0;
                    count = (count + 1) % 65536;
                end
                if (acc) begin
                    if (bus.fft_eop || idx == N - 1) begin
                        in_frame = 0;
                        drain    = 1;
                        done_at  = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
                    end else begin
                        in_frame = 1;
                        exp_idx  = idx + 1;
                    end
                end

                if (bus.dp_valid) dp_log.push_back(cyc);
                if (bus.tag_valid) tag_log.push_back('{cyc, int'(bus.bin_idx), bus.bin_first, bus.bin_last});
                if (bus.frame_done) done_cnt++;
                if (bus.err_len) len_cnt++;
                if (bus.err_nosop) nosop_cnt++;
            end
        end
    end

    task automatic drive(input bit v, input bit s, input bit e);
        bus.fft_valid = v;
        bus.fft_sop   = s;
        bus.fft_eop   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input bit v, input bit s, input bit e);
        bus2.fft_valid = v;
        bus2.fft_sop   = s;
        bus2.fft_eop   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0);
    endtask

    task automatic wait_done(input int done0, input int budget);
        int k = 0;
        while (done_cnt == done0 && k < budget) begin
            drive(0, 0, 0);
            k++;
        end
        check("frame_done_seen", done_cnt - done0, 1);
    endtask

    // Hand-computed expectations for a KEEP=4 frame: tags 0..3, first on 0, last on 3, 3-cycle latency.
    task automatic check_frame(input string name, input int d0, input int t0, input int done0,
                               input int exp_count);
        check({name, "_dp_count"}, dp_log.size() - d0, 4);
        check({name, "_tag_count"}, tag_log.size() - t0, 4);
        for (int k = 0; k < 4; k++) begin
            if (tag_log.size() > t0 + k && dp_log.size() > d0 + k) begin
                check($sformatf("%s_idx%0d", name, k), tag_log[t0+k].idx, k);
                check($sformatf("%s_first%0d", name, k), tag_log[t0+k].first, k == 0);
                check($sformatf("%s_last%0d", name, k), tag_log[t0+k].last, k == 3);
                check($sformatf("%s_lat%0d", name, k), tag_log[t0+k].cyc - dp_log[d0+k], 3);
            end
        end
        check({name, "_done_count"}, done_cnt - done0, 1);
        check({name, "_frame_count"}, bus.frame_count, exp_count);
    endtask

    initial begin
        int d0, t0, done0, len0, nosop0;
        int pos, flen;
        bit v, s, e, seen;
        bus.fft_valid = 0; bus.fft_sop = 0; bus.fft_eop = 0; bus.frame_ready = 1;
        bus2.fft_valid = 0; bus2.fft_sop = 0; bus2.fft_eop = 0; bus2.frame_ready = 1;
        reset = 1; reset2 = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        idle(2);
        check("reset_frame_count", bus.frame_count, 0);
        check("reset_tag_valid", bus.tag_valid, 0);
        check("reset_bin_idx", bus.bin_idx, 0);

        // Back-to-back frame.
        d0 = dp_log.size(); t0 = tag_log.size(); done0 = done_cnt; len0 = len_cnt;
        for (int i = 0; i < N; i++) drive(1, i == 0, i == N - 1);
        wait_done(done0, 40);
        idle(2);
        check_frame("b2b", d0, t0, done0, 1);
        check("b2b_no_err_len", len_cnt - len0, 0);

        // Same frame with gaps every other cycle.
        d0 = dp_log.size(); t0 = tag_log.size(); done0 = done_cnt;
        for (int i = 0; i < N; i++) begin
            drive(1, i == 0, i == N - 1);
            drive(0, 0, 0);
        end
        wait_done(done0, 40);
        idle(2);
        check_frame("gaps", d0, t0, done0, 2);

        // Early eop at index 5.
        d0 = dp_log.size(); t0 = tag_log.size(); done0 = done_cnt; len0 = len_cnt;
        for (int i = 0; i < 6; i++) drive(1, i == 0, i == 5);
        wait_done(done0, 40);
        idle(2);
        check_frame("eop5", d0, t0, done0, 3);
        check("eop5_err_len", len_cnt - len0, 1);

        // Stray bin in IDLE.
        d0 = dp_log.size(); nosop0 = nosop_cnt;
        drive(1, 0, 0);
        idle(3);
        check("stray_err_nosop", nosop_cnt - nosop0, 1);
        check("stray_no_dp", dp_log.size() - d0, 0);

        // sop at index 3 restarts the frame.
        d0 = dp_log.size(); t0 = tag_log.size(); done0 = done_cnt; len0 = len_cnt;
        drive(1, 1, 0); drive(1, 0, 0); drive(1, 0, 0);
        drive(1, 1, 0);
        for (int i = 1; i < N; i++) drive(1, 0, i == N - 1);
        wait_done(done0, 40);
        idle(10);
        check("restart_err_len", len_cnt - len0, 1);
        check("restart_done_once", done_cnt - done0, 1);
        check("restart_frame_count", bus.frame_count, 4);
        check("restart_dp_count", dp_log.size() - d0, 7);
        if (tag_log.size() >= t0 + 7) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("restart_idx%0d", k), tag_log[t0+3+k].idx, k);
                check($sformatf("restart_first%0d", k), tag_log[t0+3+k].first, k == 0);
            end
        end else begin
            check("restart_tag_count", tag_log.size() - t0, 7);
        end

        // frame_ready low in IDLE drops the sop bin.
        d0 = dp_log.size(); nosop0 = nosop_cnt;
        bus.frame_ready = 0;
        bus.fft_valid = 1; bus.fft_sop = 1; bus.fft_eop = 0;
        @(negedge clk);
        check("fr0_fft_ready", bus.fft_ready, 0);
        @(posedge clk); #1;
        bus.frame_ready = 1;
        idle(3);
        check("fr0_err_nosop", nosop_cnt - nosop0, 1);
        check("fr0_no_dp", dp_log.size() - d0, 0);

        // Reset at index 2.
        done0 = done_cnt; len0 = len_cnt; nosop0 = nosop_cnt;
        drive(1, 1, 0); drive(1, 0, 0);
        t0 = tag_log.size();
        reset = 1;
        drive(1, 0, 0);
        drive(0, 0, 0);
        reset = 0;
        idle(10);
        check("rst_no_done", done_cnt - done0, 0);
        check("rst_no_err_len", len_cnt - len0, 0);
        check("rst_no_err_nosop", nosop_cnt - nosop0, 0);
        check("rst_no_tags", tag_log.size() - t0, 0);
        check("rst_frame_count", bus.frame_count, 0);

        // Randomised traffic.
        pos = 0; flen = N;
        for (int k = 0; k < 3000; k++) begin
            bus.frame_ready = ($urandom_range(0, 9) != 0);
            reset = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 6);
            s = (pos == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 39) == 0);
            e = (pos == flen - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 49) == 0);
            drive(v, s, e);
            if (v) begin
                pos++;
                if (e || pos >= flen) begin
                    pos  = 0;
                    flen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : N;
                end
            end
        end
        reset = 0;
        bus.frame_ready = 1;
        idle(20);

        // 16-bit frame counter wrap on a LAT=1, KEEP=1 instance with one-bin frames.
        reset2 = 0;
        drive2(0, 0, 0);
        for (int f = 0; f < 65535; f++) begin
            drive2(1, 1, 1);
            drive2(0, 0, 0);
            drive2(0, 0, 0);
        end
        check("wrap_count_ffff", bus2.frame_count, 16'hFFFF);
        drive2(1, 1, 1);
        drive2(0, 0, 0);
        seen = bus2.frame_done;
        check("wrap_frame_done", seen, 1);
        drive2(0, 0, 0);
        check("wrap_count_zero", bus2.frame_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fft_frame_seq.md
FFT_FRAME_SEQ -- requirements
Module: fft_frame_seq

Interface
REQ-001 The block SHALL have parameters: N, default 256, FFT points per frame (power of 2, >= 8); KEEP, default N/2, bins forwarded per frame (1..N); LAT, default 3, fft_mag_sq valid-to-output latency in cycles (>= 1).
REQ-002 The block SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 The block SHALL have ports: fft_valid in 1, FFT output bin valid; fft_sop in 1, first bin of frame; fft_eop in 1, last bin of frame.
REQ-004 The block SHALL have ports: fft_ready out 1, frame-level accept to the FFT source; frame_ready in 1, downstream (spectral flux) can take a new frame.
REQ-005 The block SHALL have ports: dp_valid out 1, gated valid driven into fft_mag_sq.fft_valid.
REQ-006 The block SHALL have ports: tag_valid out 1, bin tag valid, aligned with mag_valid; bin_idx out log2(N), bin index of current mag_sq; bin_first out 1; bin_last out 1.
REQ-007 The block SHALL have ports: frame_done out 1, one-cycle pulse after the last tagged bin drains; frame_count out 16, completed-frame counter; err_len out 1, one-cycle length-error pulse; err_nosop out 1, one-cycle pulse for a stray bin.

Function
REQ-008 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-009 In IDLE, fft_ready SHALL equal frame_ready; in RUN fft_ready SHALL be 1; in DRAIN fft_ready SHALL be 0.
REQ-010 IDLE->RUN SHALL occur on fft_valid&fft_sop&fft_ready; that bin is index 0.
REQ-011 In IDLE, fft_valid without sop, or with fft_ready=0, SHALL be dropped (dp_valid=0) and SHALL pulse err_nosop next cycle.
REQ-012 The bin counter SHALL increment by 1 per accepted fft_valid in RUN; idle cycles (fft_valid=0) SHALL not change it.
REQ-013 dp_valid SHALL be combinationally fft_valid & accepted & (bin index < KEEP).
REQ-014 RUN->DRAIN SHALL occur on an accepted bin with fft_eop=1 or index N-1, whichever comes first.
REQ-015 eop at index != N-1, or index N-1 without eop, SHALL pulse err_len; the frame SHALL still complete normally.
REQ-016 sop in RUN at index != 0 SHALL pulse err_len, discard the current frame count, restart at index 0, and emit no frame_done for the aborted frame.
REQ-017 A tag pipe LAT deep SHALL carry {dp_valid, index, index==0, index==min(KEEP,N)-1 or eop}; its output SHALL drive tag_valid/bin_idx/bin_first/bin_last exactly LAT cycles after dp_valid.
REQ-018 DRAIN SHALL last until the tag pipe is empty, then pulse frame_done for one cycle, increment frame_count (16-bit wrap, 0xFFFF->0), and return to IDLE.
REQ-019 frame_done SHALL be asserted no earlier than the cycle after the final tag_valid.
REQ-020 Simultaneous err_len and frame_done in one cycle SHALL both be reported.

Reset
REQ-021 On reset, state SHALL be IDLE; bin counter, tag pipe, frame_count SHALL be 0; fft_ready, dp_valid, tag_valid, bin_first, bin_last, frame_done, err_len, err_nosop SHALL be 0; bin_idx SHALL be 0.
REQ-022 Reset asserted mid-frame SHALL flush the tag pipe with no frame_done and no error pulse; fft_ready SHALL remain 0 while reset is high.

Verification
REQ-023 N=8, KEEP=4, LAT=3, frame_ready=1, 8 back-to-back bins sop..eop -> dp_valid on bins 0-3 only; tag_valid 3 cycles later, bin_idx 0,1,2,3, bin_first on 0, bin_last on 3; frame_done 1 pulse; frame_count=1.
REQ-024 Same frame with fft_valid gaps every other cycle -> identical tag sequence, each tag exactly 3 cycles after its dp_valid.
REQ-025 eop on index 5 -> err_len pulse, frame_done pulse, frame_count increments; bin without sop in IDLE -> err_nosop, no dp_valid.
REQ-026 sop at index 3 in RUN -> err_len, index restarts at 0, exactly one frame_done after the new frame's eop.
REQ-027 frame_ready=0 in IDLE with sop pending -> fft_ready=0, bin dropped with err_nosop; reset at index 2 -> all outputs 0, no frame_done; frame_count preset by 65535 frames -> wraps to 0.
